// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a DMA loader.
// The CPU wins by default; a starved DMA request forces a two-cycle CPU stall.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WID      = 4
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_rd_addr,
    input  logic [15:0] cpu_wr_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_rd_addr,
    output logic [15:0] mem_wr_addr,
    output logic [7:0]  mem_wr_data,
    output logic        mem_wr_en,
    input  logic [7:0]  mem_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DMA_ACC = 2'd1,
        DMA_CAP = 2'd2,
        DMA_ACK = 2'd3
    } state_t;

    localparam logic [CNT_WID-1:0] LIMIT = CNT_WID'(STARVE_LIMIT);

    state_t             state_q, state_d;
    logic [CNT_WID-1:0] starve_cnt_q, starve_cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               cpu_busy;
    logic               starved;
    logic               grant;
    logic               wr_en_sel;

    assign cpu_busy = cpu_rd_en | cpu_wr_en;
    assign starved  = (starve_cnt_q == LIMIT);
    assign grant    = (state_q == IDLE) && dma_req
                   && (!cpu_busy || starved);

    // Next state, starvation counting and capture of the granted request.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d      = DMA_ACC;
                    starve_cnt_d = '0;
                    addr_d       = dma_addr;
                    wdata_d      = dma_wdata;
                    we_d         = dma_we;
                end else if (!dma_req) begin
                    starve_cnt_d = '0;
                end else if (!starved) begin
                    starve_cnt_d = starve_cnt_q + CNT_WID'(1);
                end
            end
            DMA_ACC: state_d = DMA_CAP;
            DMA_CAP: begin
                state_d = DMA_ACK;
                if (!we_q) begin
                    rdata_d = mem_dout;
                end
            end
            DMA_ACK: state_d = IDLE;
        endcase
    end

    // Memory port steering: CPU pass-through except while DMA owns it.
    always_comb begin
        mem_rd_addr = cpu_rd_addr;
        mem_wr_addr = cpu_wr_addr;
        mem_wr_data = cpu_wr_data;
        wr_en_sel   = cpu_wr_en;
        unique case (state_q)
            DMA_ACC: begin
                mem_rd_addr = addr_q;
                mem_wr_addr = addr_q;
                mem_wr_data = wdata_q;
                wr_en_sel   = we_q;
            end
            DMA_CAP: begin
                mem_rd_addr = addr_q;
                mem_wr_addr = addr_q;
                mem_wr_data = wdata_q;
                wr_en_sel   = 1'b0;
            end
            IDLE, DMA_ACK: ;
        endcase
    end

    // Reset gates the write strobe without waiting for a clock edge.
    assign mem_wr_en   = wr_en_sel & ~reset;
    assign cpu_stall   = (state_q == DMA_ACC) || (state_q == DMA_CAP);
    assign dma_ack     = (state_q == DMA_ACK);
    assign dma_rdata   = rdata_q;
    assign cpu_rd_data = mem_dout;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized bench for dmem_arbiter.
// A scoreboard queue holds the expected dma_rdata for every DMA request.
module tb_dmem_arbiter;

    localparam int LIM = 8;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        cpu_rd_en, cpu_wr_en;
    logic [15:0] cpu_rd_addr, cpu_wr_addr;
    logic [7:0]  cpu_wr_data, cpu_rd_data;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_rd_addr, mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_en;
    logic [7:0]  mem_dout;

    dmem_arbiter #(.STARVE_LIMIT(LIM), .CNT_WID(4)) dut (
        .clk100(clk100), .reset(reset),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_addr(cpu_rd_addr), .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_dout(mem_dout)
    );

    always #5 clk100 = ~clk100;

    typedef struct packed {
        logic       we;
        logic [7:0] rdata;
    } sb_t;

    sb_t        sbq[$];
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic       mem_ready = 1'b0;
    logic [7:0] exp_rd_next;
    logic [7:0] cur_rdata;
    int         checks = 0;
    int         failures = 0;
    logic       dma_done;
    logic       abort_run;

    // Synchronous-read data memory with one-cycle read latency.
    always @(posedge clk100) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0020] <= 8'h3C;
            mem[16'h0030] <= 8'h5A;
            mem_ready <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        mem_dout <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk100);
        #1;
    endtask

    task automatic smp();
        @(negedge clk100);
    endtask

    // Drive a DMA request and record what dma_rdata must show at its ack.
    task automatic issue(input logic we, input logic [15:0] a,
                         input logic [7:0] d);
        sb_t it;
        dma_we    = we;
        dma_addr  = a;
        dma_wdata = d;
        dma_req   = 1'b1;
        if (we) ref_mem[a] = d;
        else exp_rd_next = ref_mem[a];
        it.we    = we;
        it.rdata = exp_rd_next;
        sbq.push_back(it);
    endtask

    // Monitor: pops the scoreboard on each ack and checks pass-through.
    initial begin
        sb_t it;
        forever begin
            smp();
            if (!reset) begin
                chk("cpu_rd_data", 32'(cpu_rd_data), 32'(mem_dout));
                if (!cpu_stall)
                    chk("wr_passthru",
                        {7'd0, mem_wr_en,
                         cpu_wr_en ? {mem_wr_addr, mem_wr_data} : 24'd0},
                        {7'd0, cpu_wr_en,
                         cpu_wr_en ? {cpu_wr_addr, cpu_wr_data} : 24'd0});
                if (dma_ack) begin
                    chk("ack_expected", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        it = sbq.pop_front();
                        chk("dma_rdata_ack", 32'(dma_rdata), 32'(it.rdata));
                        cur_rdata = it.rdata;
                    end
                end else begin
                    chk("dma_rdata_hold", 32'(dma_rdata), 32'(cur_rdata));
                end
            end
        end
    end

    initial begin
        int n;
        int bad;
        logic idle0;
        logic [7:0] ms;
        reset = 1'b1;
        cpu_rd_en = 0; cpu_wr_en = 0;
        cpu_rd_addr = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        exp_rd_next = 0; cur_rdata = 0;
        dma_done = 0; abort_run = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        ref_mem[16'h0020] = 8'h3C;
        ref_mem[16'h0030] = 8'h5A;
        repeat (3) @(posedge clk100);
        #1 reset = 1'b0;
        smp();
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ack", 32'(dma_ack), 32'd0);
        chk("rst_rdata", 32'(dma_rdata), 32'd0);
        cyc();

        // DMA write with the CPU idle.
        issue(1'b1, 16'h0010, 8'hA5);
        smp();
        chk("wr_c0_stall", 32'(cpu_stall), 32'd0);
        cyc();
        dma_req = 0; dma_addr = 16'hFFFF; dma_wdata = 8'h00; dma_we = 0;
        smp();
        chk("wr_c1", {7'd0, mem_wr_en, mem_wr_addr, mem_wr_data},
            {7'd0, 1'b1, 16'h0010, 8'hA5});
        chk("wr_c1_stall", 32'(cpu_stall), 32'd1);
        cyc(); smp();
        chk("wr_c2", {cpu_stall, mem_wr_en}, 32'b10);
        cyc(); smp();
        chk("wr_c3", {dma_ack, cpu_stall}, 32'b10);
        repeat (2) cyc();
        chk("wr_mem", 32'(mem[16'h0010]), 32'hA5);

        // DMA read returns and holds the memory byte.
        issue(1'b0, 16'h0020, 8'h00);
        cyc();
        dma_req = 0;
        cyc(); cyc(); smp();
        chk("rd_ack", {dma_ack, dma_rdata}, {1'b1, 8'h3C});
        repeat (3) begin cyc(); smp(); end
        chk("rd_hold", 32'(dma_rdata), 32'h3C);
        cyc();

        // Starvation with a permanently busy CPU.
        cpu_rd_en = 1'b1;
        issue(1'b0, 16'h0030, 8'h00);
        for (int k = 0; k <= 11; k++) begin
            cpu_rd_addr = 16'($urandom);
            if (k == 9) dma_req = 1'b0;
            smp();
            if (k == 8)
                chk("starve_cnt", 32'(dut.starve_cnt_q), 32'(LIM));
            chk($sformatf("starve_c%0d", k), {cpu_stall, dma_ack},
                {(k == 9 || k == 10), (k == 11)});
            cyc();
        end
        cpu_rd_en = 1'b0;
        cyc();

        // Back-to-back: request held through ack is regranted in IDLE.
        issue(1'b1, 16'h0040, 8'h11);
        for (int k = 0; k <= 7; k++) begin
            smp();
            if (k == 3) chk("b2b_ack1", 32'(dma_ack), 32'd1);
            if (k == 4) chk("b2b_no_regrant", 32'(cpu_stall), 32'd0);
            if (k == 5)
                chk("b2b_grant2", {7'd0, cpu_stall, mem_wr_en, mem_wr_addr},
                    {7'd0, 1'b1, 1'b1, 16'h0041});
            if (k == 7) chk("b2b_ack2", 32'(dma_ack), 32'd1);
            cyc();
            if (k == 2) issue(1'b1, 16'h0041, 8'h22);
            if (k == 4) dma_req = 1'b0;
        end
        cyc();
        chk("b2b_mem", {mem[16'h0040], mem[16'h0041]}, 32'h1122);

        // Reset during a DMA write aborts it.
        dma_we = 1'b1; dma_addr = 16'h0050; dma_wdata = 8'h77;
        dma_req = 1'b1;
        cyc();
        dma_req = 1'b0;
        #1;
        chk("abort_acc_wr", 32'(mem_wr_en), 32'd1);
        reset = 1'b1;
        cpu_wr_en = 1'b1; cpu_wr_addr = 16'h0050; cpu_wr_data = 8'h99;
        exp_rd_next = 0; cur_rdata = 0;
        #1;
        chk("rst_async",
            {mem_wr_en, cpu_stall, dma_ack, dma_rdata},
            {1'b0, 1'b0, 1'b0, 8'h00});
        repeat (3) begin
            smp();
            chk("rst_no_ack", {mem_wr_en, dma_ack}, 32'd0);
        end
        cyc();
        cpu_wr_en = 1'b0;
        reset = 1'b0;
        repeat (4) begin
            smp();
            chk("post_rst", {cpu_stall, dma_ack}, 32'd0);
            cyc();
        end
        chk("abort_mem", 32'(mem[16'h0050]), 32'h00);

        // Randomized traffic from both masters.
        fork
            begin
                for (int t = 0; t < 150 && !abort_run; t++) begin
                    issue(1'($urandom), 16'($urandom_range(0, 255)),
                          8'($urandom));
                    n = 0;
                    idle0 = 0;
                    forever begin
                        smp();
                        if (n == 0) idle0 = !(cpu_rd_en | cpu_wr_en);
                        if (dma_ack) break;
                        n++;
                        if (n > LIM + 3) begin
                            chk("dma_ack_timeout", 32'd1, 32'd0);
                            abort_run = 1;
                            break;
                        end
                        ms = 8'(cpu_stall);
                        cyc();
                        if (ms[0]) begin
                            dma_addr  = 16'($urandom);
                            dma_wdata = 8'($urandom);
                            dma_we    = 1'($urandom);
                        end
                    end
                    if (!abort_run && idle0)
                        chk("ack_latency_idle", 32'(n), 32'd3);
                    cyc();
                    n = $urandom_range(0, 2);
                    if (n > 0) begin
                        dma_req = 1'b0;
                        repeat (n) cyc();
                    end
                end
                dma_req = 1'b0;
                dma_done = 1;
            end
            begin
                while (!dma_done) begin
                    cpu_rd_en   = ($urandom_range(0, 3) != 0);
                    cpu_wr_en   = ($urandom_range(0, 2) == 0);
                    cpu_rd_addr = 16'($urandom);
                    cpu_wr_addr = {8'h80, 8'($urandom)};
                    cpu_wr_data = 8'($urandom);
                    smp();
                    if (cpu_wr_en && !cpu_stall)
                        ref_mem[cpu_wr_addr] = cpu_wr_data;
                    cyc();
                end
                cpu_rd_en = 1'b0;
                cpu_wr_en = 1'b0;
            end
        join
        repeat (6) cyc();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        bad = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) bad++;
        chk("mem_dma_region", 32'(bad), 32'd0);
        bad = 0;
        for (int a = 16'h8000; a < 16'h8100; a++)
            if (mem[a] !== ref_mem[a]) bad++;
        chk("mem_cpu_region", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
